// File: rtl/alu_pkg.sv
// Shared ALU opcode definitions for the decode-side control and the execute stage.
package alu_pkg;

   localparam int ALU_WIDTH = 32;
   localparam int ALU_TAG_W = 5;

   typedef logic [4:0] alu_op_t;

   localparam alu_op_t ALU_ADD  = 5'd0;
   localparam alu_op_t ALU_SUB  = 5'd1;
   localparam alu_op_t ALU_AND  = 5'd2;
   localparam alu_op_t ALU_OR   = 5'd3;
   localparam alu_op_t ALU_XOR  = 5'd4;
   localparam alu_op_t ALU_NOR  = 5'd5;
   localparam alu_op_t ALU_SLL  = 5'd6;
   localparam alu_op_t ALU_SRL  = 5'd7;
   localparam alu_op_t ALU_SRA  = 5'd8;
   localparam alu_op_t ALU_SLT  = 5'd9;
   localparam alu_op_t ALU_JUMP = 5'd10;
   localparam alu_op_t ALU_BNE  = 5'd11;
   localparam alu_op_t ALU_BLEZ = 5'd12;
   localparam alu_op_t ALU_BLTZ = 5'd13;
   localparam alu_op_t ALU_BGTZ = 5'd14;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Operation-in / result-out handshake bundle between decode/control and the execute stage.
interface alu_exec_stage_if import alu_pkg::*; #(
   parameter int WIDTH = ALU_WIDTH,
   parameter int TAG_W = ALU_TAG_W
) ();

   logic             in_valid;
   logic             in_ready;
   alu_op_t          alu_ctrl;
   logic             sign;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [TAG_W-1:0] tag_in;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [TAG_W-1:0] tag_out;
   logic             zero;
   logic             cond;
   logic             ovf;
   logic             illegal;

   modport master (
      output in_valid, alu_ctrl, sign, op_a, op_b, tag_in, out_ready,
      input  in_ready, out_valid, result, tag_out, zero, cond, ovf, illegal
   );

   modport slave (
      input  in_valid, alu_ctrl, sign, op_a, op_b, tag_in, out_ready,
      output in_ready, out_valid, result, tag_out, zero, cond, ovf, illegal
   );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU: result plus zero / branch-condition / signed-overflow / illegal-opcode flags.
module alu_core import alu_pkg::*; #(
   parameter int WIDTH = ALU_WIDTH
) (
   input  alu_op_t          i_alu_ctrl,
   input  logic             i_sign,
   input  logic [WIDTH-1:0] i_op_a,
   input  logic [WIDTH-1:0] i_op_b,
   output logic [WIDTH-1:0] o_result,
   output logic             o_zero,
   output logic             o_cond,
   output logic             o_ovf,
   output logic             o_illegal
);

   localparam int MSB = WIDTH - 1;

   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic [4:0]       w_shamt;
   logic             w_lt;
   logic             w_a_is_zero;

   assign w_sum       = i_op_a + i_op_b;
   assign w_diff      = i_op_a - i_op_b;
   assign w_shamt     = i_op_a[4:0];
   assign w_lt        = i_sign ? ($signed(i_op_a) < $signed(i_op_b)) : (i_op_a < i_op_b);
   assign w_a_is_zero = (i_op_a == '0);

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      o_result  = '0;
      o_cond    = 1'b0;
      o_ovf     = 1'b0;
      o_illegal = 1'b0;
      case (i_alu_ctrl)
         ALU_ADD: begin
            o_result = w_sum;
            o_ovf    = i_sign && (i_op_a[MSB] == i_op_b[MSB]) && (w_sum[MSB] != i_op_a[MSB]);
         end
         ALU_SUB: begin
            o_result = w_diff;
            o_ovf    = i_sign && (i_op_a[MSB] != i_op_b[MSB]) && (w_diff[MSB] != i_op_a[MSB]);
         end
         ALU_AND:  o_result = i_op_a & i_op_b;
         ALU_OR:   o_result = i_op_a | i_op_b;
         ALU_XOR:  o_result = i_op_a ^ i_op_b;
         ALU_NOR:  o_result = ~(i_op_a | i_op_b);
         ALU_SLL:  o_result = i_op_b << w_shamt;
         ALU_SRL:  o_result = i_op_b >> w_shamt;
         ALU_SRA:  o_result = $signed(i_op_b) >>> w_shamt;
         ALU_SLT:  o_result = {{(WIDTH-1){1'b0}}, w_lt};
         ALU_JUMP: begin
            o_result = i_op_a;
            o_cond   = 1'b1;
         end
         ALU_BNE: begin
            o_result = w_diff;
            o_cond   = (i_op_a != i_op_b);
         end
         ALU_BLEZ: begin
            o_result = i_op_a;
            o_cond   = i_op_a[MSB] || w_a_is_zero;
         end
         ALU_BLTZ: begin
            o_result = i_op_a;
            o_cond   = i_op_a[MSB];
         end
         ALU_BGTZ: begin
            o_result = i_op_a;
            o_cond   = !i_op_a[MSB] && !w_a_is_zero;
         end
         default:  o_illegal = 1'b1;
      endcase
   end

   assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU: one-deep output register with valid/ready handshake, flush squash and sync reset.
module alu_exec_stage import alu_pkg::*; #(
   parameter int WIDTH = ALU_WIDTH,
   parameter int TAG_W = ALU_TAG_W
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           flush,
   alu_exec_stage_if.slave bus
);

   logic [WIDTH-1:0] w_result;
   logic             w_zero;
   logic             w_cond;
   logic             w_ovf;
   logic             w_illegal;
   logic             w_accept;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_result;
   logic [TAG_W-1:0] r_tag;
   logic             r_zero;
   logic             r_cond;
   logic             r_ovf;
   logic             r_illegal;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .i_alu_ctrl (bus.alu_ctrl),
      .i_sign     (bus.sign),
      .i_op_a     (bus.op_a),
      .i_op_b     (bus.op_b),
      .o_result   (w_result),
      .o_zero     (w_zero),
      .o_cond     (w_cond),
      .o_ovf      (w_ovf),
      .o_illegal  (w_illegal)
   );

   // The register can refill in the same cycle it drains, so full throughput has no bubble.
   assign bus.in_ready = !r_out_valid || bus.out_ready;
   assign w_accept     = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         // NOTE: the data fields are cleared too, because downstream observes them as zero after reset.
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_tag       <= '0;
         r_zero      <= 1'b0;
         r_cond      <= 1'b0;
         r_ovf       <= 1'b0;
         r_illegal   <= 1'b0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_result    <= w_result;
         r_tag       <= bus.tag_in;
         r_zero      <= w_zero;
         r_cond      <= w_cond;
         r_ovf       <= w_ovf;
         r_illegal   <= w_illegal;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.tag_out   = r_tag;
   assign bus.zero      = r_zero;
   assign bus.cond      = r_cond;
   assign bus.ovf       = r_ovf;
   assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized and directed bench for alu_exec_stage against an arithmetic reference model.
module tb_alu_exec_stage;

   localparam longint SMAX = 2147483647;
   localparam longint SMIN = -SMAX - 1;

   typedef struct packed {
      logic [31:0] result;
      logic [4:0]  tag;
      logic        zero;
      logic        cond;
      logic        ovf;
      logic        illegal;
   } exp_t;

   typedef struct packed {
      logic [4:0]  ctrl;
      logic        sign;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        cond;
      logic        ovf;
      logic        ill;
   } dir_t;

   logic clk;
   logic reset;
   logic flush;
   int   total;
   int   bad;
   exp_t q[$];

   alu_exec_stage_if bus ();

   alu_exec_stage u_dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain signed/unsigned 64-bit arithmetic on the operation rules.
   function automatic exp_t model(input logic [4:0] ctrl, input bit sg,
                                  input logic [31:0] a, input logic [31:0] b, input logic [4:0] tg);
      exp_t   e;
      longint sa, sb, ua, ub, t;
      int     sh;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      sh = int'(a[4:0]);
      e = '0;
      e.tag = tg;
      case (ctrl)
         5'd0: begin t = sa + sb; e.result = a + b; e.ovf = sg && (t > SMAX || t < SMIN); end
         5'd1: begin t = sa - sb; e.result = a - b; e.ovf = sg && (t > SMAX || t < SMIN); end
         5'd2: e.result = a & b;
         5'd3: e.result = a | b;
         5'd4: e.result = a ^ b;
         5'd5: e.result = ~(a | b);
         5'd6: e.result = b << sh;
         5'd7: e.result = b >> sh;
         5'd8: e.result = 32'(sb >>> sh);
         5'd9: e.result = (sg ? (sa < sb) : (ua < ub)) ? 32'd1 : 32'd0;
         5'd10: begin e.result = a; e.cond = 1'b1; end
         5'd11: begin e.result = a - b; e.cond = (a != b); end
         5'd12: begin e.result = a; e.cond = (sa <= 0); end
         5'd13: begin e.result = a; e.cond = (sa < 0); end
         5'd14: begin e.result = a; e.cond = (sa > 0); end
         default: e.illegal = 1'b1;
      endcase
      e.zero = (e.result == 32'd0);
      return e;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'hFFFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   // One clock: check outputs against the scoreboard, drive the next inputs, advance the model.
   task automatic cycle(input bit v, input logic [4:0] ctrl, input bit sg,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] tg,
                        input bit ordy, input bit fl, output bit acc, output bit dlv);
      exp_t e;
      @(negedge clk);
      total++;
      if (q.size() > 0) begin
         e = q[0];
         if ({bus.out_valid, bus.result, bus.tag_out, bus.zero, bus.cond, bus.ovf, bus.illegal} !==
             {1'b1, e.result, e.tag, e.zero, e.cond, e.ovf, e.illegal}) begin
            bad++;
            $display("FAIL out_fields t=%0t got v=%b r=%h tag=%h z=%b c=%b o=%b i=%b exp r=%h tag=%h z=%b c=%b o=%b i=%b",
                     $time, bus.out_valid, bus.result, bus.tag_out, bus.zero, bus.cond, bus.ovf,
                     bus.illegal, e.result, e.tag, e.zero, e.cond, e.ovf, e.illegal);
         end
      end else if (bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL out_valid_idle t=%0t got=%b exp=0", $time, bus.out_valid);
      end
      bus.in_valid  = v;
      bus.alu_ctrl  = ctrl;
      bus.sign      = sg;
      bus.op_a      = a;
      bus.op_b      = b;
      bus.tag_in    = tg;
      bus.out_ready = ordy;
      flush         = fl;
      #1;
      total++;
      if (bus.in_ready !== ((q.size() == 0) || ordy)) begin
         bad++;
         $display("FAIL in_ready t=%0t got=%b exp=%b", $time, bus.in_ready, (q.size() == 0) || ordy);
      end
      acc = v && ((q.size() == 0) || ordy);
      dlv = (q.size() > 0) && ordy && !fl;
      if (fl) begin
         q.delete();
      end else begin
         if (dlv) void'(q.pop_front());
         if (acc) q.push_back(model(ctrl, sg, a, b, tg));
      end
   endtask

   task automatic idle(input bit ordy);
      bit acc, dlv;
      cycle(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0, ordy, 1'b0, acc, dlv);
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.alu_ctrl  = 5'd0;
      bus.sign      = 1'b0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.tag_in    = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({bus.out_valid, bus.result, bus.tag_out, bus.zero, bus.cond, bus.ovf, bus.illegal} !== 42'd0) begin
         bad++;
         $display("FAIL reset_state got v=%b r=%h tag=%h z=%b c=%b o=%b i=%b exp all zero",
                  bus.out_valid, bus.result, bus.tag_out, bus.zero, bus.cond, bus.ovf, bus.illegal);
      end
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
      end
      reset = 1'b0;
      q.delete();
   endtask

   task automatic test_directed();
      dir_t dirs[14];
      bit   acc, dlv;
      dirs = '{
         '{5'd0,  1'b1, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b1, 1'b0},
         '{5'd0,  1'b0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b0, 1'b0},
         '{5'd1,  1'b1, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b0, 1'b1, 1'b0},
         '{5'd9,  1'b1, 32'hFFFFFFFF, 32'h1,        32'h00000001, 1'b0, 1'b0, 1'b0},
         '{5'd9,  1'b0, 32'hFFFFFFFF, 32'h1,        32'h00000000, 1'b0, 1'b0, 1'b0},
         '{5'd6,  1'b0, 32'h4,        32'h80000010, 32'h00000100, 1'b0, 1'b0, 1'b0},
         '{5'd7,  1'b0, 32'h4,        32'h80000010, 32'h08000001, 1'b0, 1'b0, 1'b0},
         '{5'd8,  1'b0, 32'h4,        32'h80000010, 32'hF8000001, 1'b0, 1'b0, 1'b0},
         '{5'd11, 1'b0, 32'h5,        32'h5,        32'h00000000, 1'b0, 1'b0, 1'b0},
         '{5'd12, 1'b0, 32'h0,        32'h0,        32'h00000000, 1'b1, 1'b0, 1'b0},
         '{5'd14, 1'b0, 32'h0,        32'h0,        32'h00000000, 1'b0, 1'b0, 1'b0},
         '{5'd13, 1'b0, 32'h80000000, 32'h0,        32'h80000000, 1'b1, 1'b0, 1'b0},
         '{5'd10, 1'b0, 32'h00400000, 32'h7,        32'h00400000, 1'b1, 1'b0, 1'b0},
         '{5'd20, 1'b1, 32'h1234,     32'h5678,     32'h00000000, 1'b0, 1'b0, 1'b1}
      };
      foreach (dirs[i]) begin
         cycle(1'b1, dirs[i].ctrl, dirs[i].sign, dirs[i].a, dirs[i].b, 5'(i), 1'b1, 1'b0, acc, dlv);
         idle(1'b1);
         total++;
         if ({bus.result, bus.zero, bus.cond, bus.ovf, bus.illegal} !==
             {dirs[i].res, dirs[i].res == 32'd0, dirs[i].cond, dirs[i].ovf, dirs[i].ill}) begin
            bad++;
            $display("FAIL directed_%0d got r=%h z=%b c=%b o=%b i=%b exp r=%h c=%b o=%b i=%b", i,
                     bus.result, bus.zero, bus.cond, bus.ovf, bus.illegal,
                     dirs[i].res, dirs[i].cond, dirs[i].ovf, dirs[i].ill);
         end
      end
      idle(1'b1);
   endtask

   task automatic test_random();
      bit          acc, dlv;
      logic [4:0]  ctrl;
      for (int n = 0; n < 400; n++) begin
         ctrl = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(15, 31)) : 5'($urandom_range(0, 14));
         cycle($urandom_range(0, 3) != 0, ctrl, 1'($urandom_range(0, 1)), pick(), pick(),
               5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
               acc, dlv);
      end
      idle(1'b1);
      idle(1'b1);
   endtask

   task automatic test_back_to_back();
      bit          acc, dlv;
      int          idx, n_dlv, last_acc;
      logic [4:0]  ctrls[4];
      logic [31:0] as[4], bs[4];
      for (int k = 0; k < 4; k++) begin
         ctrls[k] = 5'($urandom_range(0, 14));
         as[k]    = $urandom();
         bs[k]    = $urandom();
      end
      idx = 0;
      n_dlv = 0;
      last_acc = -1;
      for (int c = 0; c < 9; c++) begin
         cycle(idx < 4, ctrls[idx % 4], 1'b1, as[idx % 4], bs[idx % 4], 5'(idx + 1),
               !(c >= 1 && c <= 3), 1'b0, acc, dlv);
         if (acc) begin
            idx++;
            last_acc = c;
         end
         if (dlv) n_dlv++;
         if (c == 3) begin
            total++;
            if (idx !== 1) begin
               bad++;
               $display("FAIL stall_accepts got=%0d exp=1", idx);
            end
         end
      end
      total++;
      if (n_dlv !== 4 || idx !== 4) begin
         bad++;
         $display("FAIL b2b_count got dlv=%0d acc=%0d exp 4/4", n_dlv, idx);
      end
      total++;
      if (last_acc !== 6) begin
         bad++;
         $display("FAIL b2b_rate got last_accept_cycle=%0d exp=6", last_acc);
      end
   endtask

   task automatic test_flush();
      bit acc, dlv;
      cycle(1'b1, 5'd0, 1'b0, 32'd11, 32'd22, 5'd9, 1'b0, 1'b1, acc, dlv);
      idle(1'b0);
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL flush_accept got out_valid=%b exp=0", bus.out_valid);
      end
      cycle(1'b1, 5'd4, 1'b0, 32'hF0F0, 32'h0FF0, 5'd3, 1'b0, 1'b0, acc, dlv);
      cycle(1'b1, 5'd2, 1'b0, 32'h1, 32'h1, 5'd4, 1'b0, 1'b1, acc, dlv);
      idle(1'b1);
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL flush_stalled got out_valid=%b exp=0", bus.out_valid);
      end
      idle(1'b1);
   endtask

   task automatic test_reset_mid_stall();
      bit acc, dlv;
      cycle(1'b1, 5'd3, 1'b0, 32'hDEAD0000, 32'h0000BEEF, 5'd17, 1'b1, 1'b0, acc, dlv);
      idle(1'b0);
      reset = 1'b1;
      q.delete();
      @(negedge clk);
      total++;
      if ({bus.out_valid, bus.result, bus.tag_out, bus.zero, bus.cond, bus.ovf, bus.illegal} !== 42'd0) begin
         bad++;
         $display("FAIL reset_stall got v=%b r=%h tag=%h z=%b c=%b o=%b i=%b exp all zero",
                  bus.out_valid, bus.result, bus.tag_out, bus.zero, bus.cond, bus.ovf, bus.illegal);
      end
      reset = 1'b0;
      idle(1'b1);
      idle(1'b1);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_flush();
      test_reset_mid_stall();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute-stage ALU at the consuming end of the ALU-control interface: it accepts a 5-bit ALU operation code plus a Sign bit from the decode/control stage and executes the operation on two operands. Each operation carries a destination tag. Results, branch-condition flags and signed-overflow flags are held in an output register and released under a valid/ready handshake. It sits between the ID/EX boundary and the EX/MEM register of the pipelined MIPS core.

## Interface
- WIDTH, 32, operand/result width
- TAG_W, 5, destination-register tag width
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous squash of the output register and of any accepted input this cycle
- in_valid  input  1  operation presented
- in_ready  output  1  stage can accept this cycle
- alu_ctrl  input  5  operation code (see Operation)
- sign  input  1  1 = signed semantics for add/sub overflow and slt
- op_a  input  WIDTH  operand A (shift amount in A[4:0] for shifts)
- op_b  input  WIDTH  operand B
- tag_in  input  TAG_W  destination tag
- out_valid  output  1  result register holds a live result
- out_ready  input  1  downstream accepts
- result  output  WIDTH  registered result
- tag_out  output  TAG_W  registered tag
- zero  output  1  result == 0
- cond  output  1  branch condition true
- ovf  output  1  signed overflow (only set when sign = 1)
- illegal  output  1  alu_ctrl in 15..31

## Operation
- Codes:
  - 0 add: A+B
  - 1 sub: A-B (beq uses zero)
  - 2 and
  - 3 or
  - 4 xor
  - 5 nor
  - 6 sll: B<<A[4:0]
  - 7 srl: logical B>>A[4:0]
  - 8 sra: arithmetic B>>>A[4:0]
  - 9 slt: result = {0…,A<B}; comparison is signed if sign, else unsigned
  - 10 jump: result = A, cond = 1
  - 11 bne: result = A-B, cond = (A!=B)
  - 12 blez: result = A, cond = signed A<=0
  - 13 bltz: result = A, cond = A[WIDTH-1]
  - 14 bgtz: result = A, cond = signed A>0
  - 15..31: result = 0, illegal = 1, cond = 0
- cond = 0 for codes 0..9.
- ovf is computed for codes 0 and 1 only, and only when sign = 1:
  - add: operand MSBs equal and result MSB differs.
  - sub: operand MSBs differ and result MSB differs from A's MSB.
- ovf = 0 otherwise. The result is still written when ovf = 1; trapping belongs to the exception unit.
- All arithmetic is modulo 2^WIDTH. Shift amounts above WIDTH-1 cannot occur because only 5 bits are used.

## Timing
- Latency: 1 cycle from accepted input to out_valid.
- in_ready = !out_valid || out_ready (combinational, no bubble at full throughput).
- Accept occurs when in_valid && in_ready. On accept, the output register loads the new result and flags, and out_valid is set to 1.
- If out_valid && out_ready and there is no accept, out_valid is cleared.
- Output fields are held stable while out_valid && !out_ready.
- flush has priority over everything except reset:
  - out_valid is cleared next cycle.
  - A same-cycle accept is discarded.
  - The data fields may keep stale values.
- reset has priority over flush. Reset values: out_valid = 0, result = 0, tag_out = 0, zero = 0, cond = 0, ovf = 0, illegal = 0.
- Reset while a result is stalled: the result is discarded and not presented after reset.
- in_valid is not required to stay asserted while in_ready = 0. The stage samples inputs only on accept.

## Structure
- Shared package alu_pkg holds:
  - the 5-bit opcode constants ALU_ADD..ALU_BGTZ (0..14)
  - the opcode type
  - the WIDTH default
- The decode-side control block uses alu_pkg as well.
- One combinational sub-module, alu_core, computes {result, zero, cond, ovf, illegal} from {alu_ctrl, sign, op_a, op_b}.
- alu_exec_stage adds the handshake register and flush/reset logic.

## Test plan
- Signed-overflow add: ctrl=0, sign=1, A=0x7FFFFFFF, B=1 -> result 0x80000000, ovf=1. Same with sign=0 -> ovf=0.
- slt signed vs unsigned: ctrl=9, A=0xFFFFFFFF, B=1 -> result 1 with sign=1, result 0 with sign=0.
- Shifts with ctrl 6/7/8, A=4, B=0x80000010 -> 0x00000100, 0x08000001, 0xF8000001.
- Branches:
  - ctrl=11, A=B=5 -> cond=0, zero=1.
  - ctrl=12, A=0 -> cond=1.
  - ctrl=14, A=0 -> cond=0.
  - ctrl=13, A=0x80000000 -> cond=1.
  - ctrl=20 -> illegal=1, result 0.
- Backpressure:
  - Stream 4 ops with out_ready held 0 for 3 cycles -> in_ready=0 throughout, result held stable.
  - Release -> all 4 results delivered in order with correct tags; back-to-back at 1/cycle.
- flush and reset:
  - flush during accept with out_ready=0 -> out_valid=0 next cycle, squashed op never appears.
  - reset mid-stall -> all outputs 0 next cycle.
